// File: rtl/soc_sim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_sim_pkg
// Purpose  : Shared types and constants for the RV32I test-run controller.
//            Contents:
//            - run_state_t : controller state encoding
//            - EXIT_PASS   : tohost value that signals a passing hart
//            - hart_w()    : width of a hart index (at least one bit)
// Revision : 1.0 - initial release
// ============================================================================
package soc_sim_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } run_state_t;

  // riscv-tests convention: tohost==1 is a pass; any other odd value
  // carries a failure code in bits [31:1]; even values are syscalls.
  localparam int EXIT_PASS = 1;

  function automatic int hart_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/test_run_controller_tohost_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tohost_monitor
// Purpose  : Per-hart tohost store decoder with a sticky done flag.
// Ports    : i_clk, i_rst_n       clock, async active-low reset
//            i_clr                synchronous clear of the done flag
//            i_en                 snooping enable (controller in RUN)
//            i_st_en/addr/data    one store from the hart
//            o_pass_hit           store of EXIT_PASS to tohost this cycle
//            o_fail_hit           odd, non-pass store to tohost this cycle
//            o_fail_code          store data >> 1
//            o_done               hart has reported a pass
// Revision : 1.0 - initial release
// ============================================================================
module tohost_monitor
  import soc_sim_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h1000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic              i_st_en,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [DATA_W-1:0] i_st_data,
  output logic              o_pass_hit,
  output logic              o_fail_hit,
  output logic [DATA_W-2:0] o_fail_code,
  output logic              o_done
);

  logic w_hit;
  logic w_is_exit_pass;
  logic r_done;

  assign w_hit          = i_en & i_st_en & (i_st_addr == TOHOST_ADDR);
  assign w_is_exit_pass = (i_st_data == DATA_W'(EXIT_PASS));
  assign o_pass_hit     = w_hit & w_is_exit_pass;
  assign o_fail_hit     = w_hit & i_st_data[0] & ~w_is_exit_pass;
  assign o_fail_code    = i_st_data[DATA_W-1:1];
  assign o_done         = r_done;

  // Clear has priority so a restart discards a same-cycle pass.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done <= 1'b0;
    end else if (i_clr) begin
      r_done <= 1'b0;
    end else if (o_pass_hit) begin
      r_done <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/test_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : test_run_controller
// Purpose  : Sequences core reset, counts RUN cycles, snoops per-hart tohost
//            stores and reports a sticky PASS / FAIL / TIMEOUT verdict.
// Ports    : i_clk_in, i_reset_n  clock, async active-low reset
//            i_restart            sync pulse, back to HOLD from any state
//            i_st_en/addr/data    packed per-hart store snoop buses
//            o_core_reset         registered active-high reset to the cores
//            o_running/o_done/o_pass/o_timeout  state flags
//            o_fail_hart/o_fail_code            failing hart and its code
//            o_harts_done         per-hart pass flags
//            o_cycle_count        RUN cycles elapsed, frozen when terminal
// Revision : 1.0 - initial release
// ============================================================================
module test_run_controller
  import soc_sim_pkg::*;
#(
  parameter int                NUM_HARTS      = 1,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = 32,
  parameter int                RESET_CYCLES   = 5,
  parameter int                TIMEOUT_CYCLES = 200000,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 'h1000,
  parameter bit                HALT_ON_END    = 1'b1,
  localparam int               HART_W         = hart_w(NUM_HARTS)
) (
  input  logic                          i_clk_in,
  input  logic                          i_reset_n,
  input  logic                          i_restart,
  input  logic [NUM_HARTS-1:0]          i_st_en,
  input  logic [NUM_HARTS*ADDR_W-1:0]   i_st_addr,
  input  logic [NUM_HARTS*DATA_W-1:0]   i_st_data,
  output logic                          o_core_reset,
  output logic                          o_running,
  output logic                          o_done,
  output logic                          o_pass,
  output logic                          o_timeout,
  output logic [HART_W-1:0]             o_fail_hart,
  output logic [DATA_W-2:0]             o_fail_code,
  output logic [NUM_HARTS-1:0]          o_harts_done,
  output logic [CNT_W-1:0]              o_cycle_count
);

  localparam int                HOLD_W      = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  run_state_t          r_state,      w_state_nxt;
  logic                r_core_reset, w_core_reset_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt,   w_hold_nxt;
  logic [CNT_W-1:0]    r_cycle_cnt,  w_cycle_nxt;
  logic [HART_W-1:0]   r_fail_hart,  w_fail_hart_nxt;
  logic [DATA_W-2:0]   r_fail_code,  w_fail_code_nxt;

  logic                w_snoop_en;
  logic [NUM_HARTS-1:0] w_pass_hit;
  logic [NUM_HARTS-1:0] w_fail_hit;
  logic [NUM_HARTS-1:0] w_done;
  logic [DATA_W-2:0]   w_fail_code [NUM_HARTS];

  logic                w_any_fail;
  logic [HART_W-1:0]   w_fail_idx;
  logic [DATA_W-2:0]   w_fail_code_sel;
  logic                w_all_pass;
  logic                w_timeout_hit;

  assign w_snoop_en = (r_state == RUN);

  generate
    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
      tohost_monitor #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TOHOST_ADDR (TOHOST_ADDR)
      ) u_mon (
        .i_clk       (i_clk_in),
        .i_rst_n     (i_reset_n),
        .i_clr       (i_restart),
        .i_en        (w_snoop_en),
        .i_st_en     (i_st_en[g]),
        .i_st_addr   (i_st_addr[g*ADDR_W +: ADDR_W]),
        .i_st_data   (i_st_data[g*DATA_W +: DATA_W]),
        .o_pass_hit  (w_pass_hit[g]),
        .o_fail_hit  (w_fail_hit[g]),
        .o_fail_code (w_fail_code[g]),
        .o_done      (w_done[g])
      );
    end
  endgenerate

  // Scan from the top down so the lowest-indexed failing hart wins.
  always_comb begin
    w_any_fail      = 1'b0;
    w_fail_idx      = '0;
    w_fail_code_sel = '0;
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (w_fail_hit[i]) begin
        w_any_fail      = 1'b1;
        w_fail_idx      = HART_W'(i);
        w_fail_code_sel = w_fail_code[i];
      end
    end
  end

  // Passes landing this cycle count toward completion.
  assign w_all_pass    = &(w_done | w_pass_hit);
  assign w_timeout_hit = (r_cycle_cnt == C_CNT_LAST);

  always_comb begin
    w_state_nxt      = r_state;
    w_core_reset_nxt = r_core_reset;
    w_hold_nxt       = r_hold_cnt;
    w_cycle_nxt      = r_cycle_cnt;
    w_fail_hart_nxt  = r_fail_hart;
    w_fail_code_nxt  = r_fail_code;
    if (i_restart) begin
      w_state_nxt      = HOLD;
      w_core_reset_nxt = 1'b1;
      w_hold_nxt       = '0;
      w_cycle_nxt      = '0;
      w_fail_hart_nxt  = '0;
      w_fail_code_nxt  = '0;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_hold_cnt == C_HOLD_LAST) begin
            w_state_nxt      = RUN;
            w_core_reset_nxt = 1'b0;
          end else begin
            w_hold_nxt = r_hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          // On a terminal transition the count is not advanced, so it
          // freezes at the cycle in which the event was seen.
          if (w_any_fail) begin
            w_state_nxt     = FAIL;
            w_fail_hart_nxt = w_fail_idx;
            w_fail_code_nxt = w_fail_code_sel;
            if (HALT_ON_END) w_core_reset_nxt = 1'b1;
          end else if (w_all_pass) begin
            w_state_nxt = PASS;
            if (HALT_ON_END) w_core_reset_nxt = 1'b1;
          end else if (w_timeout_hit) begin
            w_state_nxt = TIMEOUT;
            if (HALT_ON_END) w_core_reset_nxt = 1'b1;
          end else begin
            w_cycle_nxt = r_cycle_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk_in or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= HOLD;
      r_core_reset <= 1'b1;
      r_hold_cnt   <= '0;
      r_cycle_cnt  <= '0;
      r_fail_hart  <= '0;
      r_fail_code  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_core_reset <= w_core_reset_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_cycle_cnt  <= w_cycle_nxt;
      r_fail_hart  <= w_fail_hart_nxt;
      r_fail_code  <= w_fail_code_nxt;
    end
  end

  assign o_core_reset  = r_core_reset;
  assign o_running     = (r_state == RUN);
  assign o_pass        = (r_state == PASS);
  assign o_timeout     = (r_state == TIMEOUT);
  assign o_done        = (r_state == PASS) || (r_state == FAIL) || (r_state == TIMEOUT);
  assign o_fail_hart   = r_fail_hart;
  assign o_fail_code   = r_fail_code;
  assign o_harts_done  = w_done;
  assign o_cycle_count = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_test_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_run_controller
// Purpose  : Self-checking bench for test_run_controller (2 harts).
//            Each scenario is a schedule of per-hart stores; the expected
//            verdict is derived from the schedule and queued, and a monitor
//            compares it when the DUT raises done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_run_controller;

  localparam int          N      = 2;
  localparam int          AW     = 32;
  localparam int          DW     = 32;
  localparam int          CW     = 32;
  localparam int          RC     = 5;
  localparam int          T      = 120;
  localparam int          HW     = 1;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic              clk = 1'b0;
  logic              i_reset_n = 1'b0;
  logic              i_restart = 1'b0;
  logic [N-1:0]      i_st_en = '0;
  logic [N*AW-1:0]   i_st_addr = '0;
  logic [N*DW-1:0]   i_st_data = '0;
  logic              o_core_reset, o_running, o_done, o_pass, o_timeout;
  logic [HW-1:0]     o_fail_hart;
  logic [DW-2:0]     o_fail_code;
  logic [N-1:0]      o_harts_done;
  logic [CW-1:0]     o_cycle_count;

  test_run_controller #(
    .NUM_HARTS      (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .CNT_W          (CW),
    .RESET_CYCLES   (RC),
    .TIMEOUT_CYCLES (T),
    .TOHOST_ADDR    (TOHOST),
    .HALT_ON_END    (1'b1)
  ) dut (
    .i_clk_in      (clk),
    .i_reset_n     (i_reset_n),
    .i_restart     (i_restart),
    .i_st_en       (i_st_en),
    .i_st_addr     (i_st_addr),
    .i_st_data     (i_st_data),
    .o_core_reset  (o_core_reset),
    .o_running     (o_running),
    .o_done        (o_done),
    .o_pass        (o_pass),
    .o_timeout     (o_timeout),
    .o_fail_hart   (o_fail_hart),
    .o_fail_code   (o_fail_code),
    .o_harts_done  (o_harts_done),
    .o_cycle_count (o_cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            done;
    bit            pass;
    bit            timeout;
    bit            core_reset;
    bit [HW-1:0]   fail_hart;
    bit [DW-2:0]   fail_code;
    bit [N-1:0]    harts_done;
    bit [CW-1:0]   cycle_count;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  bit        sched_en   [N][T];
  bit [31:0] sched_addr [N][T];
  bit [31:0] sched_data [N][T];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_vs(input string tag, input exp_t e);
    cmp({tag, ".done"},        o_done,        e.done);
    cmp({tag, ".running"},     o_running,     1'b0);
    cmp({tag, ".pass"},        o_pass,        e.pass);
    cmp({tag, ".timeout"},     o_timeout,     e.timeout);
    cmp({tag, ".core_reset"},  o_core_reset,  e.core_reset);
    cmp({tag, ".fail_hart"},   o_fail_hart,   e.fail_hart);
    cmp({tag, ".fail_code"},   o_fail_code,   e.fail_code);
    cmp({tag, ".harts_done"},  o_harts_done,  e.harts_done);
    cmp({tag, ".cycle_count"}, o_cycle_count, e.cycle_count);
  endtask

  task automatic check_hold(input string tag);
    exp_t e;
    e.done = 0; e.pass = 0; e.timeout = 0; e.core_reset = 1;
    e.fail_hart = '0; e.fail_code = '0; e.harts_done = '0; e.cycle_count = '0;
    check_vs(tag, e);
  endtask

  task automatic clear_sched();
    for (int h = 0; h < N; h++)
      for (int c = 0; c < T; c++) begin
        sched_en[h][c] = 0; sched_addr[h][c] = '0; sched_data[h][c] = '0;
      end
  endtask

  task automatic add_st(input int h, input int c, input bit [31:0] a, input bit [31:0] d);
    sched_en[h][c] = 1; sched_addr[h][c] = a; sched_data[h][c] = d;
  endtask

  task automatic drive_all(input bit en, input bit [31:0] a, input bit [31:0] d);
    for (int h = 0; h < N; h++) begin
      i_st_en[h] = en; i_st_addr[h*AW +: AW] = a; i_st_data[h*DW +: DW] = d;
    end
  endtask

  // Verdict from the store schedule: the run ends at the earliest of the
  // first failing store, the cycle by which every hart has passed, or the
  // last allowed cycle; failure outranks pass, pass outranks timeout.
  function automatic exp_t model();
    exp_t      e;
    int        pass_cyc [N];
    int        first_fail = T;
    int        all_pass   = 0;
    int        term;
    bit [31:0] d;
    for (int h = 0; h < N; h++) begin
      pass_cyc[h] = T;
      for (int c = 0; c < T; c++) begin
        if (sched_en[h][c] && sched_addr[h][c] == TOHOST) begin
          d = sched_data[h][c];
          if (d == 32'd1) begin
            if (pass_cyc[h] == T) pass_cyc[h] = c;
          end else if (d[0] && c < first_fail) begin
            first_fail = c;
          end
        end
      end
      if (pass_cyc[h] > all_pass) all_pass = pass_cyc[h];
    end
    term = T - 1;
    if (first_fail < term) term = first_fail;
    if (all_pass < term) term = all_pass;
    e.done = 1; e.pass = 0; e.timeout = 0; e.core_reset = 1;
    e.fail_hart = '0; e.fail_code = '0; e.cycle_count = CW'(term);
    for (int h = 0; h < N; h++) e.harts_done[h] = (pass_cyc[h] <= term);
    if (first_fail == term) begin
      for (int h = N - 1; h >= 0; h--) begin
        d = sched_data[h][term];
        if (sched_en[h][term] && sched_addr[h][term] == TOHOST && d[0] && d != 32'd1) begin
          e.fail_hart = HW'(h);
          e.fail_code = d[31:1];
        end
      end
    end else if (all_pass == term) begin
      e.pass = 1;
    end else begin
      e.timeout = 1;
    end
    return e;
  endfunction

  // Counts HOLD edges; optionally drives pass stores that must be ignored.
  task automatic wait_run(input bit hold_stores, input string tag);
    for (int k = 1; k <= RC; k++) begin
      drive_all(hold_stores, TOHOST, 32'd1);
      @(posedge clk); #1;
      if (k < RC) begin
        cmp({tag, ".hold_core_reset"}, o_core_reset, 1'b1);
        cmp({tag, ".hold_running"},    o_running,    1'b0);
      end
    end
    drive_all(1'b0, '0, '0);
    cmp({tag, ".run_core_reset"}, o_core_reset,  1'b0);
    cmp({tag, ".run_running"},    o_running,     1'b1);
    cmp({tag, ".run_cycle"},      o_cycle_count, '0);
    cmp({tag, ".run_harts_done"}, o_harts_done,  '0);
  endtask

  task automatic run_scenario(input string tag);
    exp_t e;
    bit   seen;
    e = model();
    sb_q.push_back(e);
    seen = 0;
    for (int c = 0; c < T + 5; c++) begin
      if (o_done) begin seen = 1; break; end
      for (int h = 0; h < N; h++) begin
        i_st_en[h]             = (c < T) ? sched_en[h][c] : 1'b0;
        i_st_addr[h*AW +: AW]  = (c < T) ? sched_addr[h][c] : '0;
        i_st_data[h*DW +: DW]  = (c < T) ? sched_data[h][c] : '0;
      end
      @(posedge clk); #1;
    end
    drive_all(1'b0, '0, '0);
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s.done_wait: done never rose within %0d cycles", tag, T + 5);
      void'(sb_q.pop_front());
    end
    // Terminal state must ignore further stores.
    drive_all(1'b1, TOHOST, 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    drive_all(1'b1, TOHOST, 32'd3);
    @(posedge clk); #1;
    drive_all(1'b0, '0, '0);
    check_vs({tag, ".sticky"}, e);
    cmp({tag, ".sb_drain"}, sb_q.size(), 0);
    i_restart = 1'b1;
    @(posedge clk); #1;
    i_restart = 1'b0;
    check_hold({tag, ".restart"});
    wait_run(1'b0, tag);
  endtask

  task automatic setup(input int idx);
    int k, c, r;
    bit [31:0] a, d;
    clear_sched();
    case (idx)
      0: begin add_st(0, 10, TOHOST, 1); add_st(1, 20, TOHOST, 1); end
      1: begin add_st(0, 5, TOHOST, 1);  add_st(1, 5, TOHOST, 5); end
      2: begin add_st(0, 7, TOHOST, 7);  add_st(1, 7, TOHOST, 9); end
      3: ;
      4: begin add_st(0, 100, TOHOST, 1); add_st(1, 100, TOHOST, 1); end
      5: begin add_st(0, 3, TOHOST, 1);  add_st(1, T - 1, TOHOST, 1); end
      6: begin
        add_st(0, 4, TOHOST, 2); add_st(1, 4, TOHOST + 4, 3);
        add_st(0, 6, TOHOST, 1); add_st(1, 8, TOHOST, 1);
      end
      7: begin add_st(0, 12, TOHOST, 7); add_st(1, 30, TOHOST, 1); end
      default: begin
        for (int h = 0; h < N; h++) begin
          k = $urandom_range(0, 3);
          for (int j = 0; j < k; j++) begin
            c = $urandom_range(0, T - 1);
            a = ($urandom_range(0, 3) == 0) ? $urandom : TOHOST;
            r = $urandom_range(0, 5);
            if (r <= 2)      d = 32'd1;
            else if (r == 3) d = 32'($urandom_range(1, 50) * 2 + 1);
            else if (r == 4) d = 32'($urandom_range(0, 50) * 2);
            else             d = $urandom;
            add_st(h, c, a, d);
          end
        end
      end
    endcase
  endtask

  // Scoreboard monitor: compares a queued verdict whenever done rises.
  initial begin : monitor
    exp_t e;
    bit   prev_done;
    prev_done = 0;
    forever begin
      @(negedge clk);
      if (o_done && !prev_done) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_empty: done rose with no expected verdict queued");
        end else begin
          e = sb_q.pop_front();
          check_vs("verdict", e);
        end
      end
      prev_done = o_done;
    end
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    check_hold("por");
    i_reset_n = 1'b1;
    wait_run(1'b0, "por");

    // restart beats a same-cycle pass; async reset mid-HOLD.
    repeat (30) begin @(posedge clk); #1; end
    cmp("run30.cycle", o_cycle_count, 30);
    drive_all(1'b1, TOHOST, 32'd1);
    i_restart = 1'b1;
    @(posedge clk); #1;
    i_restart = 1'b0;
    drive_all(1'b0, '0, '0);
    check_hold("restart_run");
    repeat (2) begin @(posedge clk); #1; end
    i_reset_n = 1'b0;
    #1;
    check_hold("async_reset");
    @(posedge clk); #1;
    i_reset_n = 1'b1;
    wait_run(1'b1, "hold_stores");

    for (int s = 0; s < 23; s++) begin
      setup(s);
      run_scenario($sformatf("scen%0d", s));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
